// File: rtl/cursor_pos_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cursor_pos_ctrl_pkg : button indices, step/repeat types and BCD digit split
// Revision 1.0
// ----------------------------------------------------------------------------
package cursor_pos_ctrl_pkg;

  localparam int BTN_XP = 0;
  localparam int BTN_XM = 1;
  localparam int BTN_YP = 2;
  localparam int BTN_YM = 3;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_INC  = 2'd1,
    STEP_DEC  = 2'd2
  } step_e;

  typedef enum logic [1:0] {
    REP_ST_IDLE  = 2'd0,
    REP_ST_FIRST = 2'd1,
    REP_ST_NEXT  = 2'd2
  } rep_state_e;

  // Opposing steps in the same cycle cancel out.
  function automatic step_e step_dir(input logic inc, input logic dec);
    if (inc && !dec) return STEP_INC;
    if (dec && !inc) return STEP_DEC;
    return STEP_NONE;
  endfunction

  // {tens, ones} for a value below 100, by repeated compare/subtract.
  function automatic logic [7:0] bcd_split(input logic [6:0] v);
    logic [6:0] rem;
    logic [3:0] tens;
    rem  = v;
    tens = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (rem >= 7'd10) begin
        rem  = rem - 7'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, 4'(rem)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce_rep.sv
`default_nettype none
// ----------------------------------------------------------------------------
// btn_debounce_rep : synchroniser, debounce and press/hold-repeat step pulse
// Revision 1.0
// ----------------------------------------------------------------------------
module btn_debounce_rep
  import cursor_pos_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 500_000,
  parameter int REP_DELAY = 25_000_000,
  parameter int REP_RATE  = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic step
);

  localparam int DBW     = $clog2(DB_CYCLES + 1);
  localparam int REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int RW      = $clog2(REP_MAX + 1);

  localparam logic [DBW-1:0] DB_LAST       = DBW'(DB_CYCLES - 1);
  localparam logic [RW-1:0]  REP_DELAY_CNT = RW'(REP_DELAY);
  localparam logic [RW-1:0]  REP_RATE_CNT  = RW'(REP_RATE);

  logic           sync_meta;
  logic           sync_q;
  logic           stable;
  logic [DBW-1:0] db_cnt;

  rep_state_e     rep_state;
  rep_state_e     rep_state_nxt;
  logic [RW-1:0]  rep_cnt;
  logic [RW-1:0]  rep_cnt_nxt;
  logic           press;
  logic           rep_fire;
  logic           step_q;

  // The level is accepted only after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      stable    <= 1'b0;
      db_cnt    <= '0;
    end else begin
      sync_meta <= btn_raw;
      sync_q    <= sync_meta;
      if (sync_q != stable) begin
        if (db_cnt == DB_LAST) begin
          stable <= sync_q;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_state <= REP_ST_IDLE;
      rep_cnt   <= '0;
      step_q    <= 1'b0;
    end else begin
      rep_state <= rep_state_nxt;
      rep_cnt   <= rep_cnt_nxt;
      step_q    <= press | rep_fire;
    end
  end

  // rep_cnt holds the number of cycles since the last event while held.
  always_comb begin
    rep_state_nxt = rep_state;
    rep_cnt_nxt   = rep_cnt;
    press         = 1'b0;
    rep_fire      = 1'b0;
    case (rep_state)
      REP_ST_IDLE: begin
        rep_cnt_nxt = '0;
        if (stable) begin
          press         = 1'b1;
          rep_state_nxt = REP_ST_FIRST;
          rep_cnt_nxt   = RW'(1);
        end
      end
      REP_ST_FIRST, REP_ST_NEXT: begin
        if (!stable) begin
          rep_state_nxt = REP_ST_IDLE;
          rep_cnt_nxt   = '0;
        end else if (rep_cnt == ((rep_state == REP_ST_FIRST) ? REP_DELAY_CNT : REP_RATE_CNT)) begin
          rep_fire      = 1'b1;
          rep_state_nxt = REP_ST_NEXT;
          rep_cnt_nxt   = RW'(1);
        end else begin
          rep_cnt_nxt = rep_cnt + 1'b1;
        end
      end
      default: begin
        rep_state_nxt = REP_ST_IDLE;
        rep_cnt_nxt   = '0;
      end
    endcase
  end

  assign step = step_q;

endmodule

`default_nettype wire

// File: rtl/cursor_pos_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cursor_pos_ctrl : button-driven (x,y) grid cursor with wrap/saturate and BCD
// Revision 1.0
// ----------------------------------------------------------------------------
module cursor_pos_ctrl
  import cursor_pos_ctrl_pkg::*;
#(
  parameter int COLS      = 32,
  parameter int ROWS      = 24,
  parameter int DB_CYCLES = 500_000,
  parameter int REP_DELAY = 25_000_000,
  parameter int REP_RATE  = 5_000_000,
  parameter int XW        = $clog2(COLS),
  parameter int YW        = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    btn_in,
  input  logic          wrap_en,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [15:0]   bcd,
  output logic          moved
);

  localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);

  logic [3:0]    step;
  step_e         x_dir;
  step_e         y_dir;
  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;
  logic [15:0]   bcd_nxt;
  logic          moved_nxt;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce_rep #(
      .DB_CYCLES (DB_CYCLES),
      .REP_DELAY (REP_DELAY),
      .REP_RATE  (REP_RATE)
    ) u_btn (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn_in[i]),
      .step    (step[i])
    );
  end

  always_comb begin
    x_dir = step_dir(step[BTN_XP], step[BTN_XM]);
    y_dir = step_dir(step[BTN_YP], step[BTN_YM]);
    x_nxt = x;
    y_nxt = y;

    case (x_dir)
      STEP_INC: x_nxt = (x == X_MAX) ? (wrap_en ? '0 : x) : x + 1'b1;
      STEP_DEC: x_nxt = (x == '0) ? (wrap_en ? X_MAX : x) : x - 1'b1;
      default:  x_nxt = x;
    endcase

    case (y_dir)
      STEP_INC: y_nxt = (y == Y_MAX) ? (wrap_en ? '0 : y) : y + 1'b1;
      STEP_DEC: y_nxt = (y == '0) ? (wrap_en ? Y_MAX : y) : y - 1'b1;
      default:  y_nxt = y;
    endcase

    // Built from the next values so the display never lags the position.
    bcd_nxt   = {bcd_split(7'(y_nxt)), bcd_split(7'(x_nxt))};
    moved_nxt = (x_nxt != x) || (y_nxt != y);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x     <= '0;
      y     <= '0;
      bcd   <= 16'h0000;
      moved <= 1'b0;
    end else begin
      x     <= x_nxt;
      y     <= y_nxt;
      bcd   <= bcd_nxt;
      moved <= moved_nxt;
    end
  end

endmodule

`default_nettype wire
